musa_gpio_sink: RTL and testbench



---
 rtl/musa_gpio_pkg.sv | 18 +
 rtl/gpio_fifo.sv | 66 ++++++
 rtl/musa_gpio_sink.sv | 135 +++++++++++++
 tb/tb_musa_gpio_sink.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/musa_gpio_pkg.sv
// Shared types and width helpers for the GPIO sink and its FIFO.
package musa_gpio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sink_state_t;

    // Occupancy needs one extra bit so that "full" (== depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/gpio_fifo.sv
// Synchronous show-ahead FIFO; push when full is accepted only if a pop happens in the same cycle.
module gpio_fifo
    import musa_gpio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_push,
    input  logic                            i_pop,
    input  logic [DATA_WIDTH-1:0]           i_din,
    output logic [DATA_WIDTH-1:0]           o_dout,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [cnt_w(FIFO_DEPTH)-1:0]    o_count
);

    localparam int PW = ptr_w(FIFO_DEPTH);
    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == C_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + P_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + P_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/musa_gpio_sink.sv
// Converts each rising edge of the processor's GPIO write strobe into one buffered, held display value.
// Optional macro MUSA_GPIO_SYNC_EN adds a 2-flop input synchronizer ahead of edge detection.
module musa_gpio_sink
    import musa_gpio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           gpio_i,
    input  logic                            we_gpio_i,
    input  logic                            clr_overflow_i,
    output logic [DATA_WIDTH-1:0]           disp_o,
    output logic                            disp_valid_o,
    output logic                            disp_update_o,
    output logic [cnt_w(FIFO_DEPTH)-1:0]    fifo_count_o,
    output logic                            overflow_o
);

    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] H_ONE     = HW'(1);

    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_we;
    logic                  r_we_prev;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head;
    sink_state_t           r_state;
    sink_state_t           w_next_state;
    logic [HW-1:0]         r_hold_cnt;

`ifdef MUSA_GPIO_SYNC_EN
    logic [DATA_WIDTH-1:0] r_sync_d1;
    logic [DATA_WIDTH-1:0] r_sync_d2;
    logic                  r_sync_we1;
    logic                  r_sync_we2;

    // Strobe flops reset high so a level already present is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_d1  <= '0;
            r_sync_d2  <= '0;
            r_sync_we1 <= 1'b1;
            r_sync_we2 <= 1'b1;
        end else begin
            r_sync_d1  <= gpio_i;
            r_sync_d2  <= r_sync_d1;
            r_sync_we1 <= we_gpio_i;
            r_sync_we2 <= r_sync_we1;
        end
    end

    assign w_data = r_sync_d2;
    assign w_we   = r_sync_we2;
`else
    assign w_data = gpio_i;
    assign w_we   = we_gpio_i;
`endif

    assign w_push = w_we & ~r_we_prev;

    gpio_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_data),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count_o)
    );

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (r_hold_cnt == '0) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_hold_cnt    <= '0;
            r_we_prev     <= 1'b1;
            disp_o        <= '0;
            disp_valid_o  <= 1'b0;
            disp_update_o <= 1'b0;
            overflow_o    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_we_prev     <= w_we;
            disp_update_o <= w_pop;
            if (w_pop) begin
                disp_o       <= w_head;
                disp_valid_o <= 1'b1;
                r_hold_cnt   <= HOLD_LOAD;
            end else if (r_state == HOLD && r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - H_ONE;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_push && w_full && !w_pop) begin
                overflow_o <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_musa_gpio_sink.sv
// Randomized scoreboard bench for musa_gpio_sink, modelled from display-time arithmetic and a value queue.
module tb_musa_gpio_sink;

    localparam int DW = 32;
    localparam int D  = 8;
    localparam int H  = 16;
`ifdef MUSA_GPIO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] gpio_i = '0;
    logic          we_gpio_i = 1'b1;
    logic          clr_overflow_i = 1'b0;
    logic [DW-1:0] disp_o;
    logic          disp_valid_o;
    logic          disp_update_o;
    logic [3:0]    fifo_count_o;
    logic          overflow_o;

    int n_checks = 0;
    int n_errors = 0;

    musa_gpio_sink #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .HOLD_CYCLES(H)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .gpio_i         (gpio_i),
        .we_gpio_i      (we_gpio_i),
        .clr_overflow_i (clr_overflow_i),
        .disp_o         (disp_o),
        .disp_valid_o   (disp_valid_o),
        .disp_update_o  (disp_update_o),
        .fifo_count_o   (fifo_count_o),
        .overflow_o     (overflow_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: pending-value queue plus earliest time the display may change
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mq[$];
    int            upd_cyc[$];
    int            cyc = 0;
    int            m_next = 0;
    int            m_sz;
    logic          m_prev, m_ovf, m_valid, m_upd, m_pop, m_rise, m_w;
    logic [DW-1:0] m_disp, m_d, m_v;
    logic          m_we1, m_we2;
    logic [DW-1:0] m_d1, m_d2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            m_prev  = 1'b1;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_upd   = 1'b0;
            m_disp  = '0;
            m_next  = 0;
            m_we1   = 1'b1;
            m_we2   = 1'b1;
            m_d1    = '0;
            m_d2    = '0;
        end else begin
            cyc++;
`ifdef MUSA_GPIO_SYNC_EN
            m_w   = m_we2;
            m_d   = m_d2;
            m_we2 = m_we1;
            m_d2  = m_d1;
            m_we1 = we_gpio_i;
            m_d1  = gpio_i;
`else
            m_w = we_gpio_i;
            m_d = gpio_i;
`endif
            m_sz  = mq.size();
            m_pop = (m_sz > 0) && (cyc >= m_next);
            m_upd = m_pop;
            if (m_pop) begin
                m_v = mq.pop_front();
                exp_q.push_back(m_v);
                m_disp  = m_v;
                m_valid = 1'b1;
                m_next  = cyc + H;
            end
            m_rise = m_w & ~m_prev;
            m_prev = m_w;
            if (m_rise && (m_sz < D || m_pop)) begin
                mq.push_back(m_d);
            end else if (m_rise) begin
                m_ovf = 1'b1;
            end else if (clr_overflow_i) begin
                m_ovf = 1'b0;
            end
            if (m_rise && m_sz >= D && !m_pop) begin
                m_ovf = 1'b1;
            end else if (m_rise && clr_overflow_i) begin
                m_ovf = 1'b0;
            end
        end
    end

    // monitor: compares status every cycle, pops the scoreboard on each display update
    always @(negedge clk) begin
        chk("fifo_count", DW'(fifo_count_o), DW'(mq.size()));
        chk("overflow", DW'(overflow_o), DW'(m_ovf));
        chk("disp_valid", DW'(disp_valid_o), DW'(m_valid));
        chk("disp_update", DW'(disp_update_o), DW'(m_upd));
        chk("disp_value", disp_o, m_disp);
        if (disp_update_o === 1'b1) begin
            upd_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard: update with disp_o=%h but no value expected at %0t", disp_o, $time);
            end else begin
                chk("scoreboard", disp_o, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [DW-1:0] v, input int high, input int low);
        gpio_i    = v;
        we_gpio_i = 1'b1;
        idle(high);
        we_gpio_i = 1'b0;
        idle(low);
    endtask

    initial begin
        int n;
        bit seen;

        // reset with strobe already high through release
        idle(3);
        rst_n = 1'b1;
        idle(20);
        chk("reset_no_push_count", DW'(fifo_count_o), 0);
        chk("reset_no_push_valid", DW'(disp_valid_o), 0);
        we_gpio_i = 1'b0;
        idle(3);

        // single write: latency from the rising sample to the display change
        gpio_i    = 32'hDEADBEEF;
        we_gpio_i = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = (disp_update_o === 1'b1);
        end
        chk("single_latency", DW'(n), DW'(LAT + 1));
        chk("single_value", disp_o, 32'hDEADBEEF);
        idle(10 - n);
        we_gpio_i = 1'b0;
        idle(H + 4);
        chk("single_count_zero", DW'(fifo_count_o), 0);

        // three writes spaced three cycles apart
        upd_cyc.delete();
        for (int i = 1; i <= 3; i++) write(DW'(i), 1, 2);
        idle(3 * H + 5);
        chk("three_updates", DW'(upd_cyc.size()), 3);
        if (upd_cyc.size() == 3) begin
            chk("three_gap1", DW'(upd_cyc[1] - upd_cyc[0]), DW'(H));
            chk("three_gap2", DW'(upd_cyc[2] - upd_cyc[1]), DW'(H));
        end
        chk("three_disp", disp_o, 3);
        chk("three_no_overflow", DW'(overflow_o), 0);

        // burst while holding: overflow, clear racing a drop, then plain clear
        for (int i = 0; i < 11; i++) write(32'hA000_0000 + DW'(i), 1, 1);
        chk("burst_overflow", DW'(overflow_o), 1);
        chk("burst_full", DW'(fifo_count_o), DW'(D));
        gpio_i         = 32'hBAD0_0001;
        we_gpio_i      = 1'b1;
        clr_overflow_i = 1'b1;
        idle(1);
        clr_overflow_i = 1'b0;
        we_gpio_i      = 1'b0;
        idle(1);
        chk("clr_vs_drop", DW'(overflow_o), 1);
        clr_overflow_i = 1'b1;
        idle(1);
        clr_overflow_i = 1'b0;
        idle(1);
        chk("clr_alone", DW'(overflow_o), 0);
        idle(D * H + 20);

        // asynchronous reset mid-hold with four entries queued
        for (int i = 0; i < 5; i++) write(32'h5500_0000 + DW'(i), 1, 1);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_disp", disp_o, 0);
        chk("arst_valid", DW'(disp_valid_o), 0);
        chk("arst_update", DW'(disp_update_o), 0);
        chk("arst_count", DW'(fifo_count_o), 0);
        chk("arst_overflow", DW'(overflow_o), 0);
        idle(3);
        rst_n = 1'b1;
        idle(40);
        chk("arst_no_stale_valid", DW'(disp_valid_o), 0);
        chk("arst_no_stale_disp", disp_o, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            clr_overflow_i = ($urandom_range(0, 7) == 0);
            write($urandom, $urandom_range(1, 4), $urandom_range(1, 20));
            clr_overflow_i = 1'b0;
        end
        idle(D * H + 40);
        chk("drained_scoreboard", DW'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
